font_rom_arbiter: RTL and testbench

- Shares the single synchronous font ROM (13-bit address = {char[6:0], row[5:0]}, 32-bit row word) between several text generators.
- Requesters include the date panel, the time panel and the configuration/cursor overlay.
- Arbitrates one ROM read per clock, tags each read with its requester, and returns the word to the correct requester with fixed latency.
- Sits between the text-generator blocks and font_rom; the pixel mux stays in each generator.

---
 rtl/font_rom_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/font_rom_arbiter.sv | 120 ++++++++++++
 tb/tb_font_rom_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/font_rom_pkg.sv
// Shared font ROM geometry and address helper for the text generators and the ROM arbiter.
package font_rom_pkg;

    localparam int unsigned FONT_ADDR_W  = 13;
    localparam int unsigned FONT_DATA_W  = 32;
    localparam int unsigned CHAR_W       = 7;
    localparam int unsigned ROW_W        = 6;
    localparam int unsigned FONT_ROM_LAT = 1;

    function automatic logic [FONT_ADDR_W-1:0] font_addr(input logic [CHAR_W-1:0] ch,
                                                         input logic [ROW_W-1:0]  row);
        return {ch, row};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant over an eligibility mask, pointer advances past winner.
module rr_arbiter #(
    parameter int unsigned N       = 3,
    parameter int unsigned PTR_RST = 0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned PTR_W = $clog2(N);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] sel;
    int unsigned      idx;
    logic             found;

    // Search starts at the pointer and wraps; first eligible requester wins.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        sel   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = PTR_W'(idx);
            if (!found && req_i[sel]) begin
                found      = 1'b1;
                gnt_o[sel] = 1'b1;
                ptr_d      = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= PTR_W'(PTR_RST);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/font_rom_arbiter.sv
// Shares one synchronous font ROM between text generators: arbitrates one read per clock and
// returns each word, tagged, to its requester with fixed latency.
module font_rom_arbiter
    import font_rom_pkg::*;
#(
    parameter int unsigned N_REQ   = 3,
    parameter int unsigned ADDR_W  = FONT_ADDR_W,
    parameter int unsigned DATA_W  = FONT_DATA_W,
    parameter int unsigned ROM_LAT = FONT_ROM_LAT,
    parameter int unsigned HIPRI_0 = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ*ADDR_W-1:0] addr_i,
    output logic [N_REQ-1:0]        gnt_o,
    output logic [ADDR_W-1:0]       rom_addr_o,
    input  logic [DATA_W-1:0]       rom_data_i,
    output logic [N_REQ-1:0]        rvalid_o,
    output logic [DATA_W-1:0]       rdata_o,
    input  logic                    clr_stat_i,
    output logic [15:0]             stall_cnt_o
);

    localparam int unsigned IDX_W   = $clog2(N_REQ);
    localparam int unsigned PTR_RST = (HIPRI_0 != 0) ? 1 : 0;

    typedef struct packed {
        logic             vld;
        logic [IDX_W-1:0] idx;
    } tag_t;

    logic             hipri_hit;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] rr_gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic [ADDR_W-1:0] addr_q;
    tag_t             tag_q [ROM_LAT];
    tag_t             tag_exit;
    logic [N_REQ-1:0] rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [15:0]      stall_q, stall_d;

    // Requester 0 pre-empts the rotation without moving the pointer.
    assign hipri_hit = (HIPRI_0 != 0) && req_i[0];
    assign elig      = hipri_hit ? '0 :
                       (HIPRI_0 != 0) ? (req_i & ~N_REQ'(1)) : req_i;

    rr_arbiter #(
        .N       (N_REQ),
        .PTR_RST (PTR_RST)
    ) u_rr_arbiter (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (elig),
        .gnt_o  (rr_gnt)
    );

    assign gnt_o = !rst_ni ? '0 : (hipri_hit ? N_REQ'(1) : rr_gnt);

    // Idle cycles replay the last address so the ROM bus does not toggle.
    always_comb begin
        gnt_idx    = '0;
        rom_addr_o = addr_q;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (gnt_o[k]) begin
                gnt_idx    = IDX_W'(k);
                rom_addr_o = addr_i[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign tag_exit = tag_q[ROM_LAT-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q   <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            for (int unsigned i = 0; i < ROM_LAT; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            addr_q   <= rom_addr_o;
            tag_q[0] <= '{vld: |gnt_o, idx: gnt_idx};
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (tag_exit.vld) begin
                rdata_q  <= rom_data_i;
                rvalid_q <= N_REQ'(1) << tag_exit.idx;
            end else begin
                rvalid_q <= '0;
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;

    always_comb begin
        stall_d = stall_q;
        if (clr_stat_i) begin
            stall_d = '0;
        end else if (|(req_i & ~gnt_o) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Directed bench: one instance with requester-0 priority, one pure round-robin, each with a ROM model.
module tb_font_rom_arbiter;
    import font_rom_pkg::*;

    logic        clk;
    logic        rst_n;

    logic [2:0]  req_h, gnt_h, rvalid_h;
    logic [38:0] addr_h;
    logic [12:0] rom_addr_h;
    logic [31:0] rom_data_h, rdata_h;
    logic        clr_h;
    logic [15:0] stall_h;

    logic [2:0]  req_r, gnt_r, rvalid_r;
    logic [38:0] addr_r;
    logic [12:0] rom_addr_r;
    logic [31:0] rom_data_r, rdata_r;
    logic        clr_r;
    logic [15:0] stall_r;

    int n_vec;
    int n_err;

    font_rom_arbiter #(.HIPRI_0(1)) dut_h (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req_h),
        .addr_i      (addr_h),
        .gnt_o       (gnt_h),
        .rom_addr_o  (rom_addr_h),
        .rom_data_i  (rom_data_h),
        .rvalid_o    (rvalid_h),
        .rdata_o     (rdata_h),
        .clr_stat_i  (clr_h),
        .stall_cnt_o (stall_h)
    );

    font_rom_arbiter #(.HIPRI_0(0)) dut_r (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req_r),
        .addr_i      (addr_r),
        .gnt_o       (gnt_r),
        .rom_addr_o  (rom_addr_r),
        .rom_data_i  (rom_data_r),
        .rvalid_o    (rvalid_r),
        .rdata_o     (rdata_r),
        .clr_stat_i  (clr_r),
        .stall_cnt_o (stall_r)
    );

    function automatic logic [31:0] rom_word(input logic [12:0] a);
        return {a ^ 13'h1555, 6'h2A, a};
    endfunction

    always #5 clk = ~clk;

    // One-cycle synchronous ROM models.
    always_ff @(posedge clk) begin
        rom_data_h <= rom_word(rom_addr_h);
        rom_data_r <= rom_word(rom_addr_r);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_h = '0;
        req_r = '0;
        clr_h = 1'b0;
        clr_r = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req_h  = 3'b111;
        req_r  = 3'b111;
        addr_h = {13'h1111, 13'h0222, 13'h0333};
        addr_r = {13'h1111, 13'h0222, 13'h0333};
        clr_h  = 1'b0;
        clr_r  = 1'b0;
        #2;
        n_vec++;
        if ({gnt_h, rvalid_h, rom_addr_h, rdata_h, stall_h} !== '0) begin
            n_err++;
            $display("FAIL reset_h: gnt=%b rvalid=%b rom_addr=%h rdata=%h stall=%h, want all 0",
                     gnt_h, rvalid_h, rom_addr_h, rdata_h, stall_h);
        end
        n_vec++;
        if ({gnt_r, rvalid_r, rom_addr_r, rdata_r, stall_r} !== '0) begin
            n_err++;
            $display("FAIL reset_r: gnt=%b rvalid=%b rom_addr=%h rdata=%h stall=%h, want all 0",
                     gnt_r, rvalid_r, rom_addr_r, rdata_r, stall_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_h = '0;
        req_r = '0;
    endtask

    task automatic test_single_read();
        logic [12:0] a1;
        a1 = font_addr(7'h30, 6'd5);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            req_h  = (w == 0) ? 3'b010 : 3'b000;
            addr_h = {13'h0000, a1, 13'h0000};
            #2;
            if (w == 0) begin
                n_vec++;
                if (gnt_h !== 3'b010) begin
                    n_err++;
                    $display("FAIL single_gnt: got %b want 010", gnt_h);
                end
                n_vec++;
                if (rom_addr_h !== 13'h0C05) begin
                    n_err++;
                    $display("FAIL single_rom_addr: got %h want 0c05", rom_addr_h);
                end
            end else if (w == 1) begin
                n_vec++;
                if (rvalid_h !== 3'b000) begin
                    n_err++;
                    $display("FAIL single_early_rvalid: got %b want 000", rvalid_h);
                end
            end else begin
                n_vec++;
                if (rvalid_h !== 3'b010 || rdata_h !== rom_word(13'h0C05)) begin
                    n_err++;
                    $display("FAIL single_return: rvalid=%b rdata=%h want 010 %h",
                             rvalid_h, rdata_h, rom_word(13'h0C05));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [12:0] a [3];
        logic [12:0] exp_a [8];
        logic [2:0]  exp_g;
        for (int w = 0; w < 8; w++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                a[k] = font_addr(7'(16 * k + w), 6'(w));
            end
            req_r    = (w < 6) ? 3'b111 : 3'b000;
            addr_r   = {a[2], a[1], a[0]};
            exp_a[w] = a[w % 3];
            #2;
            if (w < 6) begin
                exp_g = 3'b001 << (w % 3);
                n_vec++;
                if (gnt_r !== exp_g || rom_addr_r !== exp_a[w]) begin
                    n_err++;
                    $display("FAIL rr_gnt[%0d]: gnt=%b addr=%h want %b %h",
                             w, gnt_r, rom_addr_r, exp_g, exp_a[w]);
                end
            end
            if (w >= 2) begin
                exp_g = 3'b001 << ((w - 2) % 3);
                n_vec++;
                if (rvalid_r !== exp_g || rdata_r !== rom_word(exp_a[w-2])) begin
                    n_err++;
                    $display("FAIL rr_rvalid[%0d]: rvalid=%b rdata=%h want %b %h",
                             w, rvalid_r, rdata_r, exp_g, rom_word(exp_a[w-2]));
                end
            end
            if (w == 6) begin
                n_vec++;
                if (stall_r !== 16'd6) begin
                    n_err++;
                    $display("FAIL rr_stall: got %0d want 6", stall_r);
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [2:0] exp_g [7];
        exp_g = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};
        do_reset();
        for (int w = 0; w < 9; w++) begin
            @(negedge clk);
            req_h  = (w < 3) ? 3'b111 : (w < 7) ? 3'b110 : 3'b000;
            addr_h = {font_addr(7'h03, 6'(w)), font_addr(7'h02, 6'(w)), font_addr(7'h01, 6'(w))};
            #2;
            if (w < 7) begin
                n_vec++;
                if (gnt_h !== exp_g[w]) begin
                    n_err++;
                    $display("FAIL pri_gnt[%0d]: got %b want %b", w, gnt_h, exp_g[w]);
                end
            end
            if (w >= 2) begin
                n_vec++;
                if (rvalid_h !== exp_g[w-2]) begin
                    n_err++;
                    $display("FAIL pri_rvalid[%0d]: got %b want %b", w, rvalid_h, exp_g[w-2]);
                end
            end
            if (w == 7) begin
                n_vec++;
                if (stall_h !== 16'd7) begin
                    n_err++;
                    $display("FAIL pri_stall: got %0d want 7", stall_h);
                end
            end
        end
    endtask

    task automatic test_withdraw();
        logic [2:0] exp_g;
        logic [2:0] exp_v;
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            req_h  = (w == 0) ? 3'b101 : (w == 1) ? 3'b001 : 3'b000;
            addr_h = {13'h1ABC, 13'h0000, 13'h0123};
            exp_g  = (w < 2) ? 3'b001 : 3'b000;
            exp_v  = (w == 2 || w == 3) ? 3'b001 : 3'b000;
            #2;
            n_vec++;
            if (gnt_h !== exp_g || rvalid_h !== exp_v) begin
                n_err++;
                $display("FAIL withdraw[%0d]: gnt=%b rvalid=%b want %b %b",
                         w, gnt_h, rvalid_h, exp_g, exp_v);
            end
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        req_h  = 3'b010;
        addr_h = {13'h0000, 13'h0ABC, 13'h0000};
        #2;
        n_vec++;
        if (gnt_h !== 3'b010) begin
            n_err++;
            $display("FAIL inflight_gnt: got %b want 010", gnt_h);
        end
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        req_h = 3'b111;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if ({gnt_h, rvalid_h, rom_addr_h, rdata_h, stall_h} !== '0) begin
                n_err++;
                $display("FAIL inflight_in_reset[%0d]: gnt=%b rvalid=%b addr=%h rdata=%h st=%h",
                         i, gnt_h, rvalid_h, rom_addr_h, rdata_h, stall_h);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        req_h = 3'b000;
        for (int w = 0; w < 3; w++) begin
            #2;
            n_vec++;
            if (rvalid_h !== 3'b000) begin
                n_err++;
                $display("FAIL inflight_stale_rvalid[%0d]: got %b want 000", w, rvalid_h);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall_saturate();
        do_reset();
        @(negedge clk);
        req_h  = 3'b111;
        addr_h = {13'h0003, 13'h0002, 13'h0001};
        repeat (65534) @(negedge clk);
        #2;
        n_vec++;
        if (stall_h !== 16'hFFFE) begin
            n_err++;
            $display("FAIL stall_near_sat: got %h want fffe", stall_h);
        end
        repeat (6) @(negedge clk);
        #2;
        n_vec++;
        if (stall_h !== 16'hFFFF) begin
            n_err++;
            $display("FAIL stall_sat: got %h want ffff", stall_h);
        end
        clr_h = 1'b1;
        @(negedge clk);
        clr_h = 1'b0;
        #2;
        n_vec++;
        if (stall_h !== 16'h0000) begin
            n_err++;
            $display("FAIL stall_clr: got %h want 0000", stall_h);
        end
        @(negedge clk);
        #2;
        n_vec++;
        if (stall_h !== 16'h0001) begin
            n_err++;
            $display("FAIL stall_after_clr: got %h want 0001", stall_h);
        end
        req_h = 3'b000;
    endtask

    initial begin
        clk   = 1'b0;
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_priority();
        test_withdraw();
        test_reset_inflight();
        test_stall_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
